// File: rtl/duty_cycle_pkg.sv
// Shared types and default settings for the duty-cycle sequencer.
package duty_cycle_pkg;

  localparam int unsigned DFLT_CNT_W  = 8;
  localparam int unsigned DFLT_PERIOD = 10;
  localparam int unsigned DFLT_HIGH   = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [DFLT_CNT_W-1:0] period;
    logic [DFLT_CNT_W-1:0] high;
  } cfg_t;

endpackage

// File: rtl/duty_cycle_counter.sv
// Period position counter: wraps at i_period-1, cleared to zero while i_clear is high.
module duty_cycle_counter
  import duty_cycle_pkg::*;
#(
  parameter int unsigned CNT_W = DFLT_CNT_W
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic [CNT_W-1:0] i_period,
  output logic [CNT_W-1:0] o_cnt_nxt,
  output logic             o_last
);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign o_last = (r_cnt == i_period - CNT_W'(1));

  always_comb begin
    w_cnt_nxt = r_cnt + CNT_W'(1);
    if (i_clear || o_last) w_cnt_nxt = '0;
  end

  assign o_cnt_nxt = w_cnt_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_cnt <= '0;
    else          r_cnt <= w_cnt_nxt;
  end

endmodule

// File: rtl/duty_cycle_sequencer.sv
// Duty-cycle waveform sequencer: glitch-free start/stop, configs applied only at period boundaries.
module duty_cycle_sequencer
  import duty_cycle_pkg::*;
#(
  parameter int unsigned CNT_W      = DFLT_CNT_W,
  parameter int unsigned DEF_PERIOD = DFLT_PERIOD,
  parameter int unsigned DEF_HIGH   = DFLT_HIGH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_high,
  output logic             cfg_err,
  output logic             wave_out,
  output logic             period_start,
  output logic             busy
);

  typedef struct packed {
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] high;
  } act_cfg_t;

  state_e           r_state, w_state_nxt;
  act_cfg_t         r_act, w_act_nxt;
  act_cfg_t         r_pend, w_pend_nxt;
  logic             r_pend_vld, w_pend_vld_nxt;
  logic             w_accept, w_cfg_ok, w_last;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_wave, r_pstart, r_busy, r_err, r_ready;

  duty_cycle_counter #(.CNT_W(CNT_W)) u_counter (
    .i_clk     (clock),
    .i_rst_n   (reset_n),
    .i_clear   (r_state == IDLE),
    .i_period  (r_act.period),
    .o_cnt_nxt (w_cnt_nxt),
    .o_last    (w_last)
  );

  assign w_accept = cfg_valid && r_ready;
  assign w_cfg_ok = (cfg_period >= CNT_W'(2)) && (cfg_high <= cfg_period);

  always_comb begin
    w_state_nxt    = r_state;
    w_act_nxt      = r_act;
    w_pend_nxt     = r_pend;
    w_pend_vld_nxt = r_pend_vld;
    case (r_state)
      IDLE: begin
        if (w_accept && w_cfg_ok) w_act_nxt = '{period: cfg_period, high: cfg_high};
        if (enable) w_state_nxt = RUN;
      end
      RUN, DRAIN: begin
        if (r_state == RUN) begin
          if (!enable) w_state_nxt = DRAIN;
        end else if (enable) begin
          w_state_nxt = RUN;
        end else if (w_last) begin
          w_state_nxt = IDLE;
        end
        if (w_accept && w_cfg_ok) begin
          w_pend_nxt     = '{period: cfg_period, high: cfg_high};
          w_pend_vld_nxt = 1'b1;
        end
        // Boundary applies only what was pending before this cycle; a config taken
        // in the boundary cycle waits, unless we are dropping to IDLE.
        if ((w_last && r_pend_vld) || (w_state_nxt == IDLE && w_pend_vld_nxt)) begin
          w_act_nxt      = r_pend_vld ? r_pend : w_pend_nxt;
          w_pend_vld_nxt = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_act      <= '{period: CNT_W'(DEF_PERIOD), high: CNT_W'(DEF_HIGH)};
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_wave     <= 1'b0;
      r_pstart   <= 1'b0;
      r_busy     <= 1'b0;
      r_err      <= 1'b0;
      r_ready    <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_act      <= w_act_nxt;
      r_pend     <= w_pend_nxt;
      r_pend_vld <= w_pend_vld_nxt;
      r_wave     <= (w_state_nxt != IDLE) &&
                    (w_cnt_nxt >= w_act_nxt.period - w_act_nxt.high);
      r_pstart   <= (w_state_nxt != IDLE) && (w_cnt_nxt == '0);
      r_busy     <= (w_state_nxt != IDLE);
      r_err      <= w_accept && !w_cfg_ok;
      r_ready    <= !w_pend_vld_nxt;
    end
  end

  assign wave_out     = r_wave;
  assign period_start = r_pstart;
  assign busy         = r_busy;
  assign cfg_err      = r_err;
  assign cfg_ready    = r_ready;

endmodule

// File: tb/tb_duty_cycle_sequencer.sv
// Self-checking bench for duty_cycle_sequencer: per-cycle model comparison plus directed literals.
module tb_duty_cycle_sequencer;

  localparam int unsigned W = 8;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic         enable = 1'b0;
  logic         cfg_valid = 1'b0;
  logic [W-1:0] cfg_period = '0;
  logic [W-1:0] cfg_high = '0;
  logic         cfg_ready, cfg_err, wave_out, period_start, busy;

  int checks = 0;
  int errors = 0;

  duty_cycle_sequencer #(.CNT_W(W), .DEF_PERIOD(10), .DEF_HIGH(7)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .enable       (enable),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_period   (cfg_period),
    .cfg_high     (cfg_high),
    .cfg_err      (cfg_err),
    .wave_out     (wave_out),
    .period_start (period_start),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: position within the period, on/stop-requested flags, one pending slot.
  int m_per = 10, m_high = 7, m_pos = 0, p_per = 0, p_high = 0;
  bit m_on = 0, m_stop = 0, m_pend = 0, m_err = 0;

  initial forever begin
    bit acc, ok, last, to_idle, had;
    @(posedge clock or negedge reset_n);
    if (!reset_n) begin
      m_per = 10; m_high = 7; m_pos = 0; m_on = 0; m_stop = 0; m_pend = 0; m_err = 0;
    end else begin
      acc   = cfg_valid && !m_pend;
      ok    = (int'(cfg_period) >= 2) && (int'(cfg_high) <= int'(cfg_period));
      m_err = acc && !ok;
      if (!m_on) begin
        if (acc && ok) begin m_per = int'(cfg_period); m_high = int'(cfg_high); end
        if (enable) begin m_on = 1; m_pos = 0; end
        m_stop = 0;
      end else begin
        last    = (m_pos == m_per - 1);
        to_idle = last && m_stop && !enable;
        had     = m_pend;
        if (acc && ok) begin m_pend = 1; p_per = int'(cfg_period); p_high = int'(cfg_high); end
        if ((last && had) || (to_idle && m_pend)) begin
          m_per = p_per; m_high = p_high; m_pend = 0;
        end
        m_pos  = last ? 0 : m_pos + 1;
        m_on   = !to_idle;
        m_stop = !enable;
      end
    end
  end

  initial forever begin
    @(negedge clock);
    chk("cmp_wave",   wave_out,     m_on && (m_pos >= m_per - m_high));
    chk("cmp_pstart", period_start, m_on && (m_pos == 0));
    chk("cmp_busy",   busy,         m_on);
    chk("cmp_ready",  cfg_ready,    !m_pend);
    chk("cmp_err",    cfg_err,      m_err);
  end

  task automatic cap(input int n, output logic [15:0] wv, output logic [15:0] ps);
    wv = '0; ps = '0;
    for (int i = 0; i < n; i++) begin
      wv[i] = wave_out; ps[i] = period_start;
      @(negedge clock);
    end
  endtask

  task automatic wait_ready(input string name);
    int n; n = 0;
    while (!cfg_ready && n < 50) begin @(negedge clock); n++; end
    chk(name, cfg_ready, 1);
  endtask

  task automatic wait_pos(input string name, input int p);
    int n; n = 0;
    while (m_pos != p && n < 50) begin @(negedge clock); n++; end
    chk(name, (n < 50), 1);
  endtask

  task automatic send(input int p, input int h);
    wait_ready("send_ready");
    cfg_period = W'(p); cfg_high = W'(h); cfg_valid = 1'b1;
    @(negedge clock);
    cfg_valid = 1'b0;
  endtask

  initial begin
    logic [15:0] wv, ps;
    int n;
    repeat (3) @(negedge clock);
    chk("rst_wave", wave_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_err", cfg_err, 0);
    chk("rst_pstart", period_start, 0);

    reset_n = 1'b1; enable = 1'b1;
    @(negedge clock);
    chk("first_pstart", period_start, 1);
    chk("first_busy", busy, 1);
    cap(10, wv, ps);
    chk("dflt_pattern", wv[9:0], 32'h3F8);

    wait_pos("reach_pos2", 2);
    cfg_period = 8'd4; cfg_high = 8'd1; cfg_valid = 1'b1;
    @(negedge clock);
    cfg_valid = 1'b0;
    chk("ready_low_after_acc", cfg_ready, 0);
    wait_ready("reconfig_applied");
    cap(8, wv, ps);
    chk("p4h1_pattern", wv[7:0], 32'h88);

    send(1, 0);
    chk("err_p1_pulse", cfg_err, 1);
    @(negedge clock);
    chk("err_p1_clear", cfg_err, 0);
    send(5, 6);
    chk("err_h6_pulse", cfg_err, 1);
    @(negedge clock);
    chk("err_h6_clear", cfg_err, 0);
    wait_pos("reach_pos0", 0);
    cap(8, wv, ps);
    chk("p4h1_kept", wv[7:0], 32'h88);

    send(10, 7);
    wait_ready("p10_applied");
    wait_pos("stop_pos4", 4);
    enable = 1'b0;
    n = 0;
    do begin @(negedge clock); n++; end while (busy && n < 30);
    chk("drain_len", n, 6);
    chk("idle_wave", wave_out, 0);
    chk("idle_busy", busy, 0);

    enable = 1'b1;
    @(negedge clock);
    wait_pos("regap_pos4", 4);
    enable = 1'b0;
    @(negedge clock);
    @(negedge clock);
    enable = 1'b1;
    n = 0;
    for (int i = 0; i < 15; i++) begin
      if (busy) n++;
      @(negedge clock);
    end
    chk("no_gap_busy", n, 15);

    send(2, 0);
    wait_ready("p2h0_applied");
    cap(6, wv, ps);
    chk("p2h0_low", wv[5:0], 32'h00);
    send(2, 2);
    wait_ready("p2h2_applied");
    cap(6, wv, ps);
    chk("p2h2_high", wv[5:0], 32'h3F);
    send(2, 1);
    wait_ready("p2h1_applied");
    cap(6, wv, ps);
    chk("p2h1_wave", wv[5:0], 32'h2A);
    chk("p2h1_pstart", ps[5:0], 32'h15);

    send(2, 2);
    wait_ready("p2h2_again");
    @(negedge clock);
    send(6, 3);
    chk("pre_rst_wave", wave_out, 1);
    chk("pre_rst_ready", cfg_ready, 0);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_wave", wave_out, 0);
    chk("async_rst_ready", cfg_ready, 1);
    chk("async_rst_busy", busy, 0);
    @(negedge clock);
    #2 reset_n = 1'b1;
    @(negedge clock);
    chk("post_rst_pstart", period_start, 1);
    cap(10, wv, ps);
    chk("post_rst_pattern", wv[9:0], 32'h3F8);
    chk("post_rst_ready", cfg_ready, 1);

    enable = 1'b0;
    repeat (12) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
